// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared FSM state encoding and transfer-mode constants for the block-transfer engine.
package mem_dma_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/mem_dma_if.sv
// mem_dma_if: data-memory port; master drives address/write, slave returns combinational read data.
interface mem_dma_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_addr, mem_we, mem_wdata, input mem_rdata);
  modport slave (input mem_addr, mem_we, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_dma.sv
// mem_dma: single-channel copy/fill engine on the data-memory port with a wrapping sum of written words.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  mem_dma_if.master         bus
);
  state_t            state, state_nx;
  logic [LEN_W-1:0]  i, len_r;
  logic [ADDR_W-1:0] src_r, dst_r;
  logic [DATA_W-1:0] fill_r, data_r;
  logic              last;
  // mode is not stored: the READ/FILL branch taken at accept already encodes it
  assign last = LEN_W'(i + 1'b1) >= len_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = len == '0 ? S_DONE : mode == MODE_COPY ? S_READ : S_FILL;
      S_READ:  state_nx = S_WRITE;
      S_WRITE: state_nx = last ? S_DONE : S_READ;
      S_FILL:  state_nx = last ? S_DONE : S_FILL;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i      <= '0;
      len_r  <= '0;
      src_r  <= '0;
      dst_r  <= '0;
      fill_r <= '0;
      data_r <= '0;
      sum    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          len_r  <= len;
          src_r  <= src;
          dst_r  <= dst;
          fill_r <= fill_val;
          i      <= '0;
          sum    <= '0;
        end
        S_READ:  data_r <= bus.mem_rdata;
        S_WRITE: begin
          sum <= sum + data_r;
          i   <= i + 1'b1;
        end
        S_FILL: begin
          sum <= sum + fill_r;
          i   <= i + 1'b1;
        end
        default: ;
      endcase
    end
  assign busy          = state != S_IDLE;
  assign done          = state == S_DONE;
  assign bus.mem_we    = state == S_WRITE || state == S_FILL;
  assign bus.mem_addr  = state == S_READ ? src_r + i[ADDR_W-1:0] : bus.mem_we ? dst_r + i[ADDR_W-1:0] : '0;
  assign bus.mem_wdata = state == S_WRITE ? data_r : state == S_FILL ? fill_r : '0;
endmodule
